// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared definitions for the MEM stage: instruction codes of the
//             eight memory instructions, FSM state encoding, access-size
//             codes and small decode helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Memory instruction codes (instr_code_in encoding)
  localparam logic [5:0] C_INSTR_LB  = 6'h20;
  localparam logic [5:0] C_INSTR_LH  = 6'h21;
  localparam logic [5:0] C_INSTR_LW  = 6'h23;
  localparam logic [5:0] C_INSTR_LBU = 6'h24;
  localparam logic [5:0] C_INSTR_LHU = 6'h25;
  localparam logic [5:0] C_INSTR_SB  = 6'h28;
  localparam logic [5:0] C_INSTR_SH  = 6'h29;
  localparam logic [5:0] C_INSTR_SW  = 6'h2B;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  // Access-size codes
  localparam logic [1:0] C_SIZE_BYTE = 2'd0;
  localparam logic [1:0] C_SIZE_HALF = 2'd1;
  localparam logic [1:0] C_SIZE_WORD = 2'd2;

  function automatic logic is_load(input logic [5:0] code);
    case (code)
      C_INSTR_LB, C_INSTR_LH, C_INSTR_LW, C_INSTR_LBU, C_INSTR_LHU: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    case (code)
      C_INSTR_SB, C_INSTR_SH, C_INSTR_SW: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] access_size(input logic [5:0] code);
    case (code)
      C_INSTR_LB, C_INSTR_LBU, C_INSTR_SB: access_size = C_SIZE_BYTE;
      C_INSTR_LH, C_INSTR_LHU, C_INSTR_SH: access_size = C_SIZE_HALF;
      default:                             access_size = C_SIZE_WORD;
    endcase
  endfunction

  function automatic logic load_signed(input logic [5:0] code);
    load_signed = (code == C_INSTR_LB) || (code == C_INSTR_LH);
  endfunction

  // True when the low address bits violate the natural alignment of the access
  function automatic logic misaligned(input logic [5:0] code, input logic [1:0] a);
    case (access_size(code))
      C_SIZE_WORD: misaligned = (a != 2'b00);
      C_SIZE_HALF: misaligned = a[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align
//  Purpose  : Combinational lane steering. Produces byte enables and
//             lane-replicated write data for stores, and selects plus
//             sign/zero-extends the addressed byte/half of a load word.
//  Ports    : size, sign_ext, addr_lo, store_data, rdata -> be, wdata,
//             load_data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    w_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    case (size)
      C_SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign_ext & w_byte[7]}}, w_byte};
      end
      C_SIZE_HALF: begin
        // Only a[1] matters: a[0] is ignored, forcing half alignment
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sign_ext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM pipeline stage. Captures EX results, performs loads and
//             stores over a req/gnt/rvalid data-memory port, stalls the
//             upstream pipeline while an access is in flight and presents
//             registered MEM/WB values.
//  Ports    : clk, reset_n (async, active low); EX side: valid_in, pc_in,
//             instructure_in, instr_code_in, alu_result_in,
//             reg_read_data2_in, stall_out; memory: dm_req, dm_we, dm_addr,
//             dm_be, dm_wdata, dm_gnt, dm_rvalid, dm_rdata; WB side:
//             valid_out, pc_out, instructure_out, instr_code_out,
//             alu_result_out, mem_read_data_out, forward_data_MEM.
//  Config   : MEM_ALIGN_CHECK_EN adds exc_adel, exc_ades, badvaddr_out and
//             retires misaligned accesses as exceptions without a request.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instructure_in,
  input  logic [5:0]  instr_code_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_read_data2_in,
  output logic        stall_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instructure_out,
  output logic [5:0]  instr_code_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] forward_data_MEM
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr_out
`endif
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [5:0]  r_code;
  logic [31:0] r_alu;

  logic [5:0]  w_code;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_in_load;
  logic        w_in_store;

  // One aligner serves both directions: in IDLE it steers the incoming store,
  // afterwards it extends the load response using the held op.
  assign w_code    = (r_state == IDLE) ? instr_code_in : r_code;
  assign w_addr_lo = (r_state == IDLE) ? alu_result_in[1:0] : r_alu[1:0];
  assign w_in_load  = is_load(instr_code_in);
  assign w_in_store = is_store(instr_code_in);

  mem_align u_align (
    .size       (access_size(w_code)),
    .sign_ext   (load_signed(w_code)),
    .addr_lo    (w_addr_lo),
    .store_data (reg_read_data2_in),
    .rdata      (dm_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_data  (w_load_data)
  );

  assign stall_out        = (r_state != IDLE);
  assign forward_data_MEM = alu_result_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_pc              <= 32'd0;
      r_instr           <= 32'd0;
      r_code            <= 6'd0;
      r_alu             <= 32'd0;
      dm_req            <= 1'b0;
      dm_we             <= 1'b0;
      dm_addr           <= 32'd0;
      dm_be             <= 4'd0;
      dm_wdata          <= 32'd0;
      valid_out         <= 1'b0;
      pc_out            <= 32'd0;
      instructure_out   <= 32'd0;
      instr_code_out    <= 6'd0;
      alu_result_out    <= 32'd0;
      mem_read_data_out <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      exc_adel          <= 1'b0;
      exc_ades          <= 1'b0;
      badvaddr_out      <= 32'd0;
`endif
    end else begin
      valid_out <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            if (w_in_load || w_in_store) begin
`ifdef MEM_ALIGN_CHECK_EN
              if (misaligned(instr_code_in, alu_result_in[1:0])) begin
                valid_out         <= 1'b1;
                pc_out            <= pc_in;
                instructure_out   <= instructure_in;
                instr_code_out    <= instr_code_in;
                alu_result_out    <= alu_result_in;
                mem_read_data_out <= 32'd0;
                exc_adel          <= w_in_load;
                exc_ades          <= w_in_store;
                badvaddr_out      <= alu_result_in;
              end else
`endif
              begin
                r_pc     <= pc_in;
                r_instr  <= instructure_in;
                r_code   <= instr_code_in;
                r_alu    <= alu_result_in;
                dm_req   <= 1'b1;
                dm_we    <= w_in_store;
                dm_addr  <= {alu_result_in[31:2], 2'b00};
                dm_be    <= w_in_store ? w_be : 4'b1111;
                dm_wdata <= w_wdata;
                r_state  <= REQ;
              end
            end else begin
              valid_out         <= 1'b1;
              pc_out            <= pc_in;
              instructure_out   <= instructure_in;
              instr_code_out    <= instr_code_in;
              alu_result_out    <= alu_result_in;
              mem_read_data_out <= 32'd0;
            end
          end
        end
        REQ: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            if (is_store(r_code)) begin
              valid_out         <= 1'b1;
              pc_out            <= r_pc;
              instructure_out   <= r_instr;
              instr_code_out    <= r_code;
              alu_result_out    <= r_alu;
              mem_read_data_out <= 32'd0;
              r_state           <= IDLE;
            end else begin
              r_state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (dm_rvalid) begin
            valid_out         <= 1'b1;
            pc_out            <= r_pc;
            instructure_out   <= r_instr;
            instr_code_out    <= r_code;
            alu_result_out    <= r_alu;
            mem_read_data_out <= w_load_data;
            r_state           <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly downstream of the EX stage. Captures EX results (`pc`, instruction, `instr_code`, `alu_result`, forwarded rt data) and performs LW/LH/LHU/LB/LBU/SW/SH/SB through a request/grant/response data-memory port. Stalls the upstream pipeline while an access is in flight. Presents registered MEM/WB values to the WB stage and to the EX forwarding path.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: EX presents a live instruction this cycle.
- `pc_in` in 32: PC of the EX instruction.
- `instructure_in` in 32: raw instruction word.
- `instr_code_in` in 6: decoded instruction code, encoded per `instr.vh`.
- `alu_result_in` in 32: effective address for memory ops; result for all other ops.
- `reg_read_data2_in` in 32: forwarded rt value, used as store data.
- `stall_out` out 1: EX/ID/IF must hold their state.
- `dm_req` out 1: memory request valid.
- `dm_we` out 1: 1 = store.
- `dm_addr` out 32: word address `{alu[31:2],2'b00}`.
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_gnt` in 1: memory accepts the request this cycle.
- `dm_rvalid` in 1: load data valid.
- `dm_rdata` in 32: load data word.
- `valid_out` out 1: a retired instruction is in the MEM/WB outputs.
- `pc_out` out 32, `instructure_out` out 32, `instr_code_out` out 6, `alu_result_out` out 32: registered copies of the inputs.
- `mem_read_data_out` out 32: extended load result; 0 for non-loads.
- `forward_data_MEM` out 32: equals `alu_result_out`.
- `exc_adel` out 1, `exc_ades` out 1, `badvaddr_out` out 32: present only with `MEM_ALIGN_CHECK_EN`.

## Operation
FSM with three states: IDLE, REQ, WAIT_R.
- IDLE, `valid_in`=1, non-memory op: the edge loads the MEM/WB registers and sets `valid_out`=1. The FSM stays in IDLE.
- IDLE, `valid_in`=1, memory op: the edge latches the op into the hold register and moves to REQ. `valid_out` is 0 on the next cycle.
- REQ: `dm_req`=1. `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are held stable until `dm_gnt`.
  - Store with `dm_gnt`: MEM/WB registers load, `valid_out`=1, next state IDLE.
  - Load with `dm_gnt`: next state WAIT_R.
- WAIT_R: `dm_req`=0. On `dm_rvalid`, load the extended data and the held fields into MEM/WB, set `valid_out`=1, go to IDLE.
- `dm_rvalid` is ignored in IDLE and REQ.
- `stall_out` = (state != IDLE), combinational.
- `valid_out` is a one-cycle pulse per retired instruction. It is 0 in every bubble cycle; the other MEM/WB outputs hold their last values.
- Byte lanes, with `a` = `alu[1:0]`:
  - SW: `be`=1111.
  - SH: `be` = `a[1]` ? 1100 : 0011; `wdata` = `{2{rt[15:0]}}`.
  - SB: `be` = 0001<<`a`; `wdata` = `{4{rt[7:0]}}`.
  - Loads: `be`=1111. LB/LBU select byte `a`; LH/LHU select half `a[1]`. Sign- or zero-extend to 32 bits.
- Reset (async, any state): FSM goes to IDLE, `dm_req`=0, all outputs = 0. An outstanding response after reset is discarded by the IDLE rule.

## Timing
- Non-memory op: retires 1 cycle after acceptance.
- Store with zero-wait grant: `valid_out` 2 cycles after acceptance.
- Load with zero-wait grant and rvalid one cycle after gnt: `valid_out` 3 cycles after acceptance.
- Each cycle of `dm_gnt` or `dm_rvalid` delay adds one cycle to these latencies.
- `dm_req` is registered from state. The earliest `dm_req` is the cycle after acceptance.
- `stall_out` is 0 in the acceptance cycle, and 1 from the following cycle until the retirement edge.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: ports `exc_adel`, `exc_ades` and `badvaddr_out` exist.
  - A misaligned LW/SW (`a`≠00) or LH/LHU/SH (`a[0]`=1) never issues `dm_req`.
  - It retires one cycle after acceptance with `exc_adel` (load) or `exc_ades` (store) = 1 for one cycle, and `badvaddr_out` = `alu_result_in`.
- Undefined: these ports are absent. Low address bits beyond the access size are ignored, and the access is forced aligned.

## Structure
- Add `instr_code` values for the eight memory instructions to `instr.vh`.
- Add the FSM state encodings (IDLE=2'd0, REQ=2'd1, WAIT_R=2'd2) and the access-size codes (byte/half/word) to `constant.vh`.
- One combinational sub-module, `mem_align`, handles size/offset → `be`/`wdata`, and `rdata` → extended load data.

## Test plan
- ALU op, `alu_result_in`=0x0000_1234 -> `valid_out` the next cycle, `alu_result_out`=0x1234, `stall_out` never 1.
- SB `rt`=0xAABBCC5A, addr 0x103, gnt delayed 2 cycles -> `dm_be`=1000, `dm_wdata`=0x5A5A5A5A stable for 3 cycles, `stall_out` 3 cycles, `valid_out` once.
- LB addr 0x102, `rdata`=0x0080_0000 -> `mem_read_data_out`=0xFFFFFF80. LBU on the same inputs -> 0x00000080.
- LH addr 0x2, `rdata`=0x8001_0000 -> 0xFFFF8001. LHU -> 0x00008001.
- `reset_n` low while in WAIT_R, then `dm_rvalid` after release -> FSM IDLE, `valid_out` stays 0, `dm_req`=0.
- With `MEM_ALIGN_CHECK_EN`: LW addr 0x6 -> no `dm_req`; `exc_adel`=1 and `badvaddr_out`=0x6 one cycle after acceptance.
